// File: rtl/psx_device_responder.sv
// PSX pad responder: emulates a DualShock-style controller on the host's att_n/psx_clk/cmd link.
// Optional build macro PSX_ANALOG_MODE_EN adds the analog port and the 9-byte analog reply.
module psx_device_responder #(
  parameter int ACK_DELAY = 100,
  parameter int ACK_WIDTH = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        att_n,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic [15:0] buttons_n,
`ifdef PSX_ANALOG_MODE_EN
  input  logic [31:0] analog,
`endif
  output logic        dat,
  output logic        ack_n,
  output logic        busy,
  output logic        poll_done,
  output logic [7:0]  last_cmd
);

`ifdef PSX_ANALOG_MODE_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
  localparam logic [7:0] ID_BYTE  = 8'h73;
`else
  localparam logic [3:0] LAST_IDX = 4'd4;
  localparam logic [7:0] ID_BYTE  = 8'h41;
`endif
  localparam logic [15:0] DELAY_END = 16'(ACK_DELAY - 1);
  localparam logic [15:0] WIDTH_END = 16'(ACK_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK_PULSE, DONE} state_t;

  logic att_p0, att_p1, att_p2;
  logic sck_p0, sck_p1, sck_p2;
  logic cmd_p0, cmd_p1;

  // stage p0/p1: synchronizers; stage p2: history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      att_p0 <= 1'b1;
      att_p1 <= 1'b1;
      att_p2 <= 1'b1;
      sck_p0 <= 1'b1;
      sck_p1 <= 1'b1;
      sck_p2 <= 1'b1;
      cmd_p0 <= 1'b1;
      cmd_p1 <= 1'b1;
    end else begin
      att_p0 <= att_n;
      att_p1 <= att_p0;
      att_p2 <= att_p1;
      sck_p0 <= psx_clk;
      sck_p1 <= sck_p0;
      sck_p2 <= sck_p1;
      cmd_p0 <= cmd;
      cmd_p1 <= cmd_p0;
    end
  end

  logic att_fall, att_rise, sck_fall, sck_rise;
  assign att_fall = att_p2 & ~att_p1;
  assign att_rise = ~att_p2 & att_p1;
  assign sck_fall = sck_p2 & ~sck_p1;
  assign sck_rise = ~sck_p2 & sck_p1;

  state_t      state, state_d;
  logic [3:0]  byte_idx;
  logic [2:0]  bit_idx;
  logic [15:0] cnt;
  logic [6:0]  rx_shift;
  logic [15:0] btn_q;
`ifdef PSX_ANALOG_MODE_EN
  logic [31:0] ana_q;
`endif
  logic [7:0]  rx_byte;
  logic        load, shift_out, shift_in, ack_on, ack_off, resync, poll_ok;

  assign rx_byte = {cmd_p1, rx_shift};

  function automatic logic reply_bit(input logic [3:0] idx, input logic [2:0] pos);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'hFF;
      4'd1:    b = ID_BYTE;
      4'd2:    b = 8'h5A;
      4'd3:    b = btn_q[7:0];
      4'd4:    b = btn_q[15:8];
`ifdef PSX_ANALOG_MODE_EN
      4'd5:    b = ana_q[7:0];
      4'd6:    b = ana_q[15:8];
      4'd7:    b = ana_q[23:16];
      4'd8:    b = ana_q[31:24];
`endif
      default: b = 8'hFF;
    endcase
    reply_bit = b[pos];
  endfunction

  always_comb begin
    state_d   = state;
    load      = 1'b0;
    shift_out = 1'b0;
    shift_in  = 1'b0;
    ack_on    = 1'b0;
    ack_off   = 1'b0;
    resync    = 1'b0;
    poll_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (att_fall) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_out = sck_fall;
        if (sck_rise) begin
          shift_in = 1'b1;
          if (bit_idx == 3'd7) begin
            if (byte_idx == 4'd0 && rx_byte != 8'h01)
              state_d = DONE;
            else if (byte_idx == 4'd1 && rx_byte != 8'h42)
              state_d = DONE;
            else if (byte_idx == LAST_IDX) begin
              state_d = DONE;
              poll_ok = 1'b1;
            end else
              state_d = ACK_WAIT;
          end
        end
      end
      ACK_WAIT: begin
        if (sck_fall) begin
          resync  = 1'b1;
          state_d = SHIFT;
        end else if (cnt == DELAY_END) begin
          ack_on  = 1'b1;
          state_d = ACK_PULSE;
        end
      end
      ACK_PULSE: begin
        // an early host clock edge ends the pulse and starts the next byte
        if (sck_fall) begin
          resync  = 1'b1;
          state_d = SHIFT;
        end else if (cnt == WIDTH_END) begin
          ack_off = 1'b1;
          state_d = SHIFT;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (att_rise) begin
      state_d = IDLE;
      poll_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dat       <= 1'b1;
      ack_n     <= 1'b1;
      busy      <= 1'b0;
      poll_done <= 1'b0;
      last_cmd  <= 8'h00;
      byte_idx  <= 4'd0;
      bit_idx   <= 3'd0;
      cnt       <= 16'd0;
    end else begin
      state     <= state_d;
      poll_done <= poll_ok;
      if (state_d != state)
        cnt <= 16'd0;
      else if (state == ACK_WAIT || state == ACK_PULSE)
        cnt <= cnt + 16'd1;
      if (att_rise) begin
        dat   <= 1'b1;
        ack_n <= 1'b1;
        busy  <= 1'b0;
      end else begin
        if (load) begin
          byte_idx <= 4'd0;
          bit_idx  <= 3'd0;
          busy     <= 1'b1;
        end
        if (shift_out)
          dat <= reply_bit(byte_idx, bit_idx);
        if (shift_in) begin
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7 && byte_idx == 4'd1)
            last_cmd <= rx_byte;
        end
        if (ack_on)
          ack_n <= 1'b0;
        if (ack_off || resync) begin
          ack_n    <= 1'b1;
          byte_idx <= byte_idx + 4'd1;
        end
        if (resync)
          dat <= reply_bit(byte_idx + 4'd1, 3'd0);
        if (state_d == DONE)
          dat <= 1'b1;
      end
    end
  end

  // receive shifter and reply snapshot are pure data, no reset needed
  always_ff @(posedge clk) begin
    if (shift_in && bit_idx != 3'd7)
      rx_shift[bit_idx] <= cmd_p1;
    if (load) begin
      btn_q <= buttons_n;
`ifdef PSX_ANALOG_MODE_EN
      ana_q <= analog;
`endif
    end
  end

endmodule

// File: tb/tb_psx_device_responder.sv
// Bench for psx_device_responder: host poller model plus scoreboard of reply bytes and
// per-transaction outcomes (ack count/timing, poll_done, last_cmd, abort release).
`timescale 1ns/1ps
module tb_psx_device_responder;
  localparam int ACK_DELAY = 100;
  localparam int ACK_WIDTH = 200;
  localparam int HALF      = 50;   // 40 ns clk -> 2 us half period, 250 kHz
  localparam int GAP       = ACK_DELAY + ACK_WIDTH + 50;
`ifdef PSX_ANALOG_MODE_EN
  localparam int         NPOLL = 9;
  localparam logic [7:0] ID    = 8'h73;
`else
  localparam int         NPOLL = 5;
  localparam logic [7:0] ID    = 8'h41;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        att_n = 1'b1;
  logic        psx_clk = 1'b1;
  logic        cmd = 1'b1;
  logic [15:0] buttons_n = 16'hFFFF;
`ifdef PSX_ANALOG_MODE_EN
  logic [31:0] analog = 32'h0;
`endif
  logic        dat, ack_n, busy, poll_done;
  logic [7:0]  last_cmd;

  psx_device_responder #(.ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut (
    .clk(clk), .rst(rst), .att_n(att_n), .psx_clk(psx_clk), .cmd(cmd),
    .buttons_n(buttons_n),
`ifdef PSX_ANALOG_MODE_EN
    .analog(analog),
`endif
    .dat(dat), .ack_n(ack_n), .busy(busy), .poll_done(poll_done), .last_cmd(last_cmd)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct { int acks; int polls; int lc; } rec_t;
  logic [7:0] exp_q[$];
  rec_t       rec_q[$];

  int rise_cyc = 0;
  int att_cyc  = 0;

  // reply byte monitor: host samples dat on each psx_clk rising edge
  logic [7:0] rx_sh = 8'h00;
  int         nbit = 0;
  always @(posedge psx_clk or posedge att_n) begin
    if (att_n)
      nbit = 0;
    else begin
      rx_sh[nbit] = dat;
      nbit++;
      if (nbit == 8) begin
        nbit = 0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=0x%0h required=none", rx_sh);
        end else
          chk("reply_byte", int'(rx_sh), int'(exp_q.pop_front()));
      end
    end
  end

  // ack / poll_done / transaction-end monitor
  logic ack_prev = 1'b1;
  logic busy_prev = 1'b0;
  int   fall_cyc = 0, n_ack = 0, n_poll = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ack_prev && !ack_n) begin
        n_ack++;
        chk("ack_delay", cyc - rise_cyc, ACK_DELAY + 3);
        fall_cyc = cyc;
      end
      if (!ack_prev && ack_n)
        chk("ack_width", cyc - fall_cyc, ACK_WIDTH);
      if (poll_done)
        n_poll++;
      if (!busy_prev && busy) begin
        n_ack  = 0;
        n_poll = 0;
      end
      if (busy_prev && !busy) begin
        if (rec_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_busy_fall actual=0 required=1");
        end else begin
          rec_t r;
          r = rec_q.pop_front();
          chk("ack_count", n_ack, r.acks);
          chk("poll_done_count", n_poll, r.polls);
          chk("last_cmd", int'(last_cmd), r.lc);
          chk("release_latency", cyc - att_cyc, 3);
          chk("dat_released", int'(dat), 1);
          chk("ack_n_released", int'(ack_n), 1);
        end
      end
    end
    ack_prev  = ack_n;
    busy_prev = busy;
  end

  logic [7:0]  host_cmd[9];
  logic [7:0]  exp_rep[9];
  int          chg_byte = -1;
  logic [15:0] chg_val = 16'h0000;

  task automatic send_bits(input logic [7:0] c, input int nb);
    for (int b = 0; b < nb; b++) begin
      psx_clk = 1'b0;
      cmd = c[b];
      repeat (HALF) @(negedge clk);
      psx_clk = 1'b1;
      if (b == 7) rise_cyc = cyc;
      repeat (HALF) @(negedge clk);
    end
    cmd = 1'b1;
  endtask

  task automatic wait_ack();
    int t;
    t = 0;
    while (ack_n && t < 2000) begin @(negedge clk); t++; end
    if (ack_n) begin
      checks++; failures++;
      $display("FAIL ack_timeout actual=1 required=0");
    end
    t = 0;
    while (!ack_n && t < 2000) begin @(negedge clk); t++; end
    if (!ack_n) begin
      checks++; failures++;
      $display("FAIL ack_stuck_low actual=0 required=1");
    end
  endtask

  task automatic set_poll(input logic [15:0] btn);
    buttons_n = btn;
    for (int i = 0; i < 9; i++) begin
      host_cmd[i] = 8'h00;
      exp_rep[i]  = 8'hFF;
    end
    host_cmd[0] = 8'h01;
    host_cmd[1] = 8'h42;
    exp_rep[1]  = ID;
    exp_rep[2]  = 8'h5A;
    exp_rep[3]  = btn[7:0];
    exp_rep[4]  = btn[15:8];
`ifdef PSX_ANALOG_MODE_EN
    exp_rep[5]  = analog[7:0];
    exp_rep[6]  = analog[15:8];
    exp_rep[7]  = analog[23:16];
    exp_rep[8]  = analog[31:24];
`endif
  endtask

  task automatic transact(input int nbytes, input int nack, input int npoll,
                          input int lc, input int abort_bits);
    rec_t r;
    r.acks = nack; r.polls = npoll; r.lc = lc;
    rec_q.push_back(r);
    att_n = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < nbytes; i++) begin
      if (i == chg_byte) buttons_n = chg_val;
      exp_q.push_back(exp_rep[i]);
      send_bits(host_cmd[i], 8);
      if (i < nack) wait_ack();
      else repeat (GAP) @(negedge clk);
    end
    if (abort_bits > 0) send_bits(host_cmd[nbytes], abort_bits);
    att_n = 1'b1;
    att_cyc = cyc;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_dat", int'(dat), 1);
    chk("reset_ack_n", int'(ack_n), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_poll_done", int'(poll_done), 0);
    chk("reset_last_cmd", int'(last_cmd), 0);

    // wrong address: device stays silent, dat high
    set_poll(16'hFFF7);
    host_cmd[0] = 8'h81;
    exp_rep[1] = 8'hFF;
    exp_rep[2] = 8'hFF;
    transact(3, 0, 0, 8'h00, 0);

    // digital poll with START pressed
    set_poll(16'hFFF7);
    transact(NPOLL, NPOLL - 1, 1, 8'h42, 0);

    // unsupported command
    set_poll(16'hFFF7);
    host_cmd[1] = 8'h43;
    transact(2, 1, 0, 8'h43, 0);

    // abort after 3 bits of byte3 (byte3 = 00 so dat is low at the abort)
    set_poll(16'hFF00);
    transact(3, 3, 0, 8'h42, 3);
    set_poll(16'hA5C3);
    transact(NPOLL, NPOLL - 1, 1, 8'h42, 0);

    // buttons change during byte2 must not reach this reply
    set_poll(16'hFFFF);
    chg_byte = 2;
    chg_val = 16'h0000;
    transact(NPOLL, NPOLL - 1, 1, 8'h42, 0);
    chg_byte = -1;
    set_poll(16'h0000);
    transact(NPOLL, NPOLL - 1, 1, 8'h42, 0);

`ifdef PSX_ANALOG_MODE_EN
    analog = 32'h807F1020;
    set_poll(16'hFFF7);
    transact(NPOLL, NPOLL - 1, 1, 8'h42, 0);
`endif

    repeat (10) @(negedge clk);
    chk("byte_queue_empty", exp_q.size(), 0);
    chk("record_queue_empty", rec_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_200_000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
